btn_debounce_multi: RTL and testbench

Parametrised N-channel push-button conditioner: successor to the single-channel debouncer, placed between the board push-buttons (setpoint up/down, mode, alarm-ack) and the temperature-control FSM. Each channel synchronises its raw input, qualifies it with a symmetric stability counter, and emits a clean level plus one-cycle rise, fall, long-press and auto-repeat strobes. Channels are fully independent; all outputs are registered.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_debounce_ch.sv | 129 ++++++++++++
 rtl/btn_debounce_multi.sv | 40 ++++
 tb/tb_btn_debounce_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel push-button conditioner:
// per-channel state encoding and default timing at a 50 MHz clock.
package btn_pkg;

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_GO_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_GO_LOW  = 2'd3;

    typedef enum logic [1:0] {
        S_LOW     = ST_LOW,
        S_GO_HIGH = ST_GO_HIGH,
        S_HIGH    = ST_HIGH,
        S_GO_LOW  = ST_GO_LOW
    } btn_state_e;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DB_CYC      = 65536;       // ~1.3 ms
    localparam int unsigned DEF_LONG_CYC    = 50_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYC  = 10_000_000;  // 200 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: synchroniser, symmetric stability debouncer and
// hold timer producing level, rise/fall, long-press and auto-repeat strobes.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DB_CYC      = DEF_DB_CYC,
    parameter int unsigned LONG_CYC    = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic rpt
);

    localparam int unsigned DW = $clog2(DB_CYC);
    localparam int unsigned HW = $clog2(max_u(LONG_CYC, REPEAT_CYC) + 1);
    localparam logic [DW-1:0] DB_END   = DW'(DB_CYC - 1);
    localparam logic [HW-1:0] LONG_END = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] RPT_END  = (REPEAT_CYC == 0) ? '0 : HW'(REPEAT_CYC - 1);
    localparam bit            RPT_EN   = (REPEAT_CYC != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    btn_state_e             state;
    logic [DW-1:0]          dcnt;
    logic [HW-1:0]          hcnt;
    logic                   lp;
    logic                   fall_now;

    assign s = sync[SYNC_STAGES-1];

    // A completing release suppresses any long/repeat strobe on the same cycle.
    assign fall_now = (state == S_GO_LOW) && !s && (dcnt == DB_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= '0;
            state      <= S_LOW;
            dcnt       <= '0;
            hcnt       <= '0;
            lp         <= 1'b0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], btn_in};
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_press <= 1'b0;
            rpt        <= 1'b0;

            // Hold timer keeps running through GO_LOW so short dropouts do not restart it.
            if (level && !fall_now) begin
                if (!lp && hcnt == LONG_END) begin
                    long_press <= 1'b1;
                    lp         <= 1'b1;
                    hcnt       <= '0;
                end else if (lp && RPT_EN && hcnt == RPT_END) begin
                    rpt  <= 1'b1;
                    hcnt <= '0;
                end else if (hcnt != '1) begin
                    hcnt <= hcnt + HW'(1);
                end
            end

            case (state)
                S_LOW: begin
                    if (s) begin
                        state <= S_GO_HIGH;
                        dcnt  <= DW'(1);
                    end else begin
                        dcnt  <= '0;
                    end
                end
                S_GO_HIGH: begin
                    if (!s) begin
                        state <= S_LOW;
                        dcnt  <= '0;
                    end else if (dcnt == DB_END) begin
                        state <= S_HIGH;
                        dcnt  <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        hcnt  <= '0;
                        lp    <= 1'b0;
                    end else begin
                        dcnt  <= dcnt + DW'(1);
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state <= S_GO_LOW;
                        dcnt  <= DW'(1);
                    end else begin
                        dcnt  <= '0;
                    end
                end
                S_GO_LOW: begin
                    if (s) begin
                        state <= S_HIGH;
                        dcnt  <= '0;
                    end else if (dcnt == DB_END) begin
                        state <= S_LOW;
                        dcnt  <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        hcnt  <= '0;
                        lp    <= 1'b0;
                    end else begin
                        dcnt  <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= S_LOW;
                    dcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner; channels are independent copies of
// btn_debounce_ch sharing only clock and reset.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DB_CYC      = DEF_DB_CYC,
    parameter int unsigned LONG_CYC    = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_rpt
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYC      (DB_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_in     (btn_in[i]),
            .level      (btn_level[i]),
            .rise       (btn_rise[i]),
            .fall       (btn_fall[i]),
            .long_press (btn_long[i]),
            .rpt        (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios with cycle-exact expectations
// plus random presses, all checked against a run-length / hold-age model.
module tb_btn_debounce_multi;

    localparam int N  = 2;
    localparam int SY = 2;
    localparam int DB = 4;
    localparam int LG = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long, btn_rpt;
    logic [5*N-1:0] obs;

    int tests = 0;
    int fails = 0;

    // Model: per channel, input history, consecutive-disagreement run, level, hold age.
    logic [SY-1:0] m_sync [N];
    int            m_run  [N];
    logic          m_lvl  [N];
    int            m_age  [N];
    logic [N-1:0]  e_level, e_rise, e_fall, e_long, e_rpt;

    btn_debounce_multi #(
        .N_CH        (N),
        .SYNC_STAGES (SY),
        .DB_CYC      (DB),
        .LONG_CYC    (LG),
        .REPEAT_CYC  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_long  (btn_long),
        .btn_rpt   (btn_rpt)
    );

    always #5 clk = ~clk;

    assign obs = {btn_level, btn_rise, btn_fall, btn_long, btn_rpt};

    function automatic logic [5*N-1:0] exp_vec();
        return {e_level, e_rise, e_fall, e_long, e_rpt};
    endfunction

    function automatic void model_step(input logic [N-1:0] v, input logic r);
        for (int ch = 0; ch < N; ch++) begin
            logic s, rose, fell;
            rose = 1'b0;
            fell = 1'b0;
            e_long[ch] = 1'b0;
            e_rpt[ch]  = 1'b0;
            if (r) begin
                m_sync[ch] = '0;
                m_run[ch]  = 0;
                m_lvl[ch]  = 1'b0;
                m_age[ch]  = 0;
            end else begin
                s = m_sync[ch][SY-1];
                m_sync[ch] = {m_sync[ch][SY-2:0], v[ch]};
                // A change is accepted after DB consecutive disagreeing samples.
                if (s != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DB) begin
                        m_run[ch] = 0;
                        if (m_lvl[ch]) fell = 1'b1;
                        else           rose = 1'b1;
                        m_lvl[ch] = ~m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
                if (rose || fell) begin
                    m_age[ch] = 0;
                end else if (m_lvl[ch]) begin
                    m_age[ch]++;
                    if (m_age[ch] == LG)
                        e_long[ch] = 1'b1;
                    else if (RP > 0 && m_age[ch] > LG && ((m_age[ch] - LG) % RP) == 0)
                        e_rpt[ch] = 1'b1;
                end
            end
            e_level[ch] = m_lvl[ch];
            e_rise[ch]  = rose;
            e_fall[ch]  = fell;
        end
    endfunction

    // Apply one cycle of stimulus, then advance the model past the same edge.
    task automatic step(input logic [N-1:0] v, input logic r);
        btn_in = v;
        reset  = r;
        @(posedge clk);
        #1;
        model_step(v, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step('1, 1'b1);
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_outputs i=%0d got %b exp 0", i, obs);
            end
        end
        idle(3);
        tests++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle got %b exp %b", obs, exp_vec());
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 20; i++) begin
            step(2'b01, 1'b0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL clean_model i=%0d got %b exp %b", i, obs, exp_vec());
            end
            tests++;
            if (btn_rise[0] !== (i == 5) || btn_level[0] !== (i >= 5) ||
                {btn_level[1], btn_rise[1], btn_fall[1], btn_long[1], btn_rpt[1]} !== 5'b0) begin
                fails++;
                $display("FAIL clean_timing i=%0d got lvl=%b rise=%b exp lvl=%b rise=%b",
                         i, btn_level, btn_rise, (i >= 5), (i == 5));
            end
        end
        idle(20);
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b1111_1111_0111;   // LSB first: 1,1,1,0, then held
        for (int i = 0; i < 16; i++) begin
            step({1'b0, (i < 12) ? pat[i] : 1'b1}, 1'b0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL bounce_model i=%0d got %b exp %b", i, obs, exp_vec());
            end
            tests++;
            if (btn_rise[0] !== (i == 9)) begin
                fails++;
                $display("FAIL bounce_rise i=%0d got %b exp %b", i, btn_rise[0], (i == 9));
            end
        end
        idle(20);
    endtask

    task automatic test_long_repeat();
        logic v;
        for (int i = 0; i < 45; i++) begin
            v = (i < 31) && !(i == 20 || i == 21);
            step({1'b0, v}, 1'b0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL hold_model i=%0d got %b exp %b", i, obs, exp_vec());
            end
            tests++;
            if (btn_long[0] !== (i == 15) ||
                btn_rpt[0] !== (i > 15 && i < 36 && ((i - 15) % 3) == 0) ||
                btn_fall[0] !== (i == 36)) begin
                fails++;
                $display("FAIL hold_sched i=%0d got long=%b rpt=%b fall=%b", i,
                         btn_long[0], btn_rpt[0], btn_fall[0]);
            end
        end
        idle(5);
    endtask

    task automatic test_reset_mid_press();
        for (int i = 0; i < 22; i++) begin
            step(2'b01, (i == 8));
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_model i=%0d got %b exp %b", i, obs, exp_vec());
            end
            tests++;
            if (btn_fall[0] !== 1'b0 || btn_rise[0] !== (i == 5 || i == 14) ||
                (i == 8 && obs !== '0)) begin
                fails++;
                $display("FAIL midrst_timing i=%0d got rise=%b fall=%b obs=%b", i,
                         btn_rise[0], btn_fall[0], obs);
            end
        end
        idle(20);
    endtask

    task automatic test_two_channels();
        for (int i = 0; i < 26; i++) begin
            step({(i < 8), 1'b1}, 1'b0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL twoch_model i=%0d got %b exp %b", i, obs, exp_vec());
            end
            tests++;
            if (btn_rise !== ((i == 5) ? 2'b11 : 2'b00) ||
                btn_fall !== ((i == 13) ? 2'b10 : 2'b00) ||
                btn_long !== ((i == 15) ? 2'b01 : 2'b00)) begin
                fails++;
                $display("FAIL twoch_timing i=%0d got rise=%b fall=%b long=%b", i,
                         btn_rise, btn_fall, btn_long);
            end
        end
        idle(20);
    endtask

    task automatic test_random();
        logic [N-1:0] cur;
        logic         r;
        cur = '0;
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(5) == 0) cur[ch] = ~cur[ch];
            r = ($urandom_range(199) == 0);
            step(cur, r);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random_model i=%0d in=%b got %b exp %b", i, cur, obs, exp_vec());
            end
        end
    endtask

    initial begin
        btn_in = '0;
        reset  = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_reset_mid_press();
        test_two_channels();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
